// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns round stage: latches a 128-bit state, then produces
// one output column per cycle through a single shared MixColumns column datapath.
module shift_mix_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         final_round,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         o_en,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] lat_q, lat_d;
  logic         fin_q, fin_d;
  logic [127:0] work_q, work_d;
  logic [127:0] dout_q, dout_d;
  logic         o_en_q, o_en_d;

  logic [7:0] a [4];
  logic [7:0] m [4];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Column col of the ShiftRows result: row r comes from input column (col+r) mod 4.
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = lat_q[127 - 8*((((int'(col_q) + r) % 4) * 4) + r) -: 8];
    end
  end

  always_comb begin
    if (fin_q) begin
      for (int unsigned r = 0; r < 4; r++) m[r] = a[r];
    end else begin
      m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
      m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
      m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
      m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    lat_d   = lat_q;
    fin_d   = fin_q;
    work_d  = work_q;
    dout_d  = dout_q;
    o_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          lat_d   = data_in;
          fin_d   = final_round;
          col_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned r = 0; r < 4; r++) begin
          work_d[127 - 8*(4*int'(col_q) + r) -: 8] = m[r];
        end
        col_d = col_q + 2'd1;
        // The last column goes straight into data_out alongside the work register.
        if (col_q == 2'd3) begin
          state_d = IDLE;
          dout_d  = work_d;
          o_en_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      lat_q   <= '0;
      fin_q   <= 1'b0;
      work_q  <= '0;
      dout_q  <= '0;
      o_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
      fin_q   <= fin_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      o_en_q  <= o_en_d;
    end
  end

  assign data_out = dout_q;
  assign o_en     = o_en_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_shift_mix_stage.sv
// Directed bench for shift_mix_stage: expected blocks are queued at start and
// checked (value and completion cycle) whenever o_en is seen.
module tb_shift_mix_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_en;
  logic         final_round;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         o_en;
  logic         busy;

  shift_mix_stage dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .final_round (final_round),
    .data_in     (data_in),
    .data_out    (data_out),
    .o_en        (o_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int unsigned  due;
  } exp_t;

  exp_t        sb [$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [127:0] V1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V2_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] V2_OUT = 128'he9317db5cb322c723d2e895faf090794;
  // Bytes placed on the diagonal so the post-ShiftRows column 0 is db135345.
  localparam logic [127:0] V3_IN  = 128'hdb000000001300000000530000000045;
  localparam logic [127:0] V3_OUT = 128'h8e4da1bc000000000000000000000000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every o_en must match the oldest queued block and cycle.
  always @(negedge clk) begin
    if (o_en === 1'b1) begin
      chk("busy_low_at_o_en", {127'd0, busy}, 128'd0);
      if (sb.size() == 0) begin
        chk("unexpected_o_en", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", data_out, e.data);
        chk("latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  task automatic start(input logic [127:0] d, input logic f, input logic [127:0] exp);
    data_in     = d;
    final_round = f;
    i_en        = 1'b1;
    sb.push_back('{exp, cyc + 5});
    tick();
    i_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      chk("timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b0; i_en = 1'b0; final_round = 1'b0; data_in = '0;
    tick(); tick();
    chk("reset_data_out", data_out, 128'd0);
    chk("reset_o_en", {127'd0, o_en}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    rst = 1'b1;
    tick();

    // Mixed round, known FIPS-197 vector
    start(V1_IN, 1'b0, V1_OUT);
    data_in = '1; final_round = 1'b1;   // late changes must not matter
    wait_done();
    tick(); tick();
    chk("data_out_hold", data_out, V1_OUT);

    // Final round: ShiftRows only
    start(V2_IN, 1'b1, V2_OUT);
    wait_done();

    // Single column, then all zeros
    start(V3_IN, 1'b0, V3_OUT);
    wait_done();
    start('0, 1'b0, '0);
    wait_done();

    // Second i_en two cycles into a block is ignored; busy high for 4 cycles
    start(V1_IN, 1'b0, V1_OUT);
    chk("busy_c1", {127'd0, busy}, 128'd1);
    tick();
    chk("busy_c2", {127'd0, busy}, 128'd1);
    data_in = V2_IN; final_round = 1'b1; i_en = 1'b1;
    tick();
    i_en = 1'b0;
    chk("busy_c3", {127'd0, busy}, 128'd1);
    tick();
    chk("busy_c4", {127'd0, busy}, 128'd1);
    tick();
    chk("busy_c5_low", {127'd0, busy}, 128'd0);
    wait_done();
    for (int i = 0; i < 6; i++) tick();   // any stray o_en is flagged by the monitor

    // i_en held high over two blocks: second is latched in the first o_en cycle
    data_in = V2_IN; final_round = 1'b1; i_en = 1'b1;
    sb.push_back('{V2_OUT, cyc + 5});
    tick();
    data_in = V1_IN; final_round = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    sb.push_back('{V1_OUT, cyc + 5});
    tick();
    i_en = 1'b0;
    wait_done();
    tick();

    // Reset in the RUN cycle with col=2 aborts the block
    start(V3_IN, 1'b0, V3_OUT);
    tick(); tick();
    rst = 1'b0;
    sb.delete();
    tick();
    chk("abort_data_out", data_out, 128'd0);
    chk("abort_o_en", {127'd0, o_en}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    rst = 1'b1;
    start(V2_IN, 1'b1, V2_OUT);        // accepted on the first edge with rst=1
    wait_done();

    // Reset wins over i_en on the same edge
    rst = 1'b0; i_en = 1'b1; data_in = V1_IN; final_round = 1'b0;
    tick();
    chk("rst_prio_busy", {127'd0, busy}, 128'd0);
    rst = 1'b1; i_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_prio_no_out", data_out, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 The module SHALL have port i_en, input, 1 bit: start request, sampled on the rising clk edge.
REQ-004 The module SHALL have port final_round, input, 1 bit: sampled with i_en; 1 means skip MixColumns (ShiftRows only).
REQ-005 The module SHALL have port data_in, input, 128 bits: AES state after SubBytes.
REQ-006 The module SHALL have port data_out, output, 128 bits: ShiftRows(+MixColumns) result.
REQ-007 The module SHALL have port o_en, output, 1 bit: one-cycle pulse marking a new data_out.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a block is in progress.

Function
REQ-009 Byte k (k=0..15) SHALL be data[127-8k -: 8]; state element s[r][c] SHALL be byte 4c+r, so column c = bytes 4c..4c+3 (FIPS-197 order).
REQ-010 ShiftRows SHALL compute t[r][c] = s[r][(c+r) mod 4] for r,c in 0..3.
REQ-011 MixColumns SHALL compute, per column in GF(2^8) with modulus 0x11B: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3.
REQ-012 xtime(b) SHALL be {b[6:0],0} XOR (b[7] ? 8'h1B : 8'h00); 3b SHALL be xtime(b)^b; all arithmetic SHALL be 8-bit with no carry out.
REQ-013 The FSM SHALL have states IDLE and RUN plus a 2-bit column counter col.
REQ-014 In IDLE, when i_en=1, the rising edge SHALL latch data_in and final_round into internal registers, set col=0, and enter RUN.
REQ-015 In RUN, each edge SHALL compute one output column (column col of the ShiftRows result, mixed unless the latched final_round=1) into a 128-bit work register, then increment col.
REQ-016 Exactly one MixColumns column datapath SHALL exist, shared across the four RUN cycles.
REQ-017 On the edge that writes column 3, the FSM SHALL return to IDLE, load data_out with the full 128-bit result, and set o_en=1.
REQ-018 Latency SHALL be: i_en sampled at edge E0; o_en high and data_out valid during the cycle after edge E4.
REQ-019 o_en SHALL be high for exactly one cycle per accepted block; data_out SHALL hold its value until the next completion.
REQ-020 busy SHALL equal (state==RUN); it SHALL be low in the cycle that o_en is high.
REQ-021 i_en asserted while busy=1 SHALL be ignored: no latch, no restart, and no effect on the block in flight.
REQ-022 i_en=1 in the o_en cycle (IDLE) SHALL be accepted, giving back-to-back throughput of one block per 5 cycles.
REQ-023 Changes on data_in or final_round after E0 SHALL NOT affect the block in flight.

Reset
REQ-024 When rst=0 at a rising edge, the module SHALL set state=IDLE, col=0, o_en=0, busy=0, data_out=128'h0, and clear the work and latch registers.
REQ-025 Reset asserted mid-RUN SHALL abort the block with no o_en pulse, and the module SHALL accept i_en on the first edge after rst returns to 1.
REQ-026 Reset SHALL take priority over i_en on the same edge.

Verification
REQ-027 The bench SHALL drive data_in=d42711aee0bf98f1b8b45de51e415230 with final_round=0 and i_en pulsed, and check data_out=046681e5e0cb199a48f8d37a2806264c with o_en high exactly 5 cycles after the i_en edge.
REQ-028 The bench SHALL drive data_in=e9098972cb31075f3d327d94af2e2cb5 with final_round=1, and check data_out=e9317db5cb322c723d2e895faf090794.
REQ-029 The bench SHALL issue a start with column 0 = db135345 and the remaining bytes 0, with final_round=0, and check data_out[127:96]=8e4da1bc, the ShiftRows-scattered zeros elsewhere, and that an all-zero input gives all-zero output.
REQ-030 The bench SHALL pulse i_en again two cycles after a start, and check that a single o_en pulse occurs, the result matches the first input, and busy stays high for 4 cycles.
REQ-031 The bench SHALL hold i_en=1 continuously over two blocks, and check that o_en pulses every 5 cycles and that the second block is the one latched in the first o_en cycle.
REQ-032 The bench SHALL assert rst=0 during the RUN cycle with col=2, and check that outputs are zero, no o_en pulse occurs, and a new start completes correctly.
